multicycle_addsub: RTL and testbench
====================================

MULTICYCLE_ADDSUB -- requirements
Module: multicycle_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the operand and result width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, meaning the bits processed per clock. WIDTH SHALL be an integer multiple of CHUNK, and CHUNK SHALL be >= 1. NCH = WIDTH/CHUNK.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: operation request, sampled on a rising edge.
REQ-006 SHALL have port mode, input, 1 bit: 0 = add, 1 = subtract (a - b).
REQ-007 SHALL have port a, input, WIDTH bits: operand A.
REQ-008 SHALL have port b, input, WIDTH bits: operand B.
REQ-009 SHALL have port cin, input, 1 bit: carry-in for add; ignored when mode=1.
REQ-010 SHALL have port busy, output, 1 bit: high while chunks are being processed.
REQ-011 SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-012 SHALL have port sum, output, WIDTH bits: registered result.
REQ-013 SHALL have port cout, output, 1 bit: carry out of the MSB. For subtract, 1 = no borrow.
REQ-014 SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and DONE.
REQ-016 In IDLE or DONE, with start=1, SHALL on that edge:
- latch a into an operand register;
- latch b (mode=0) or ~b (mode=1) into a second operand register;
- set the carry register to cin (mode=0) or 1 (mode=1);
- clear the chunk counter to 0;
- enter RUN.
REQ-017 In RUN, each edge SHALL:
- add chunk bits [k*CHUNK +: CHUNK] of both operand registers plus the carry;
- store the CHUNK-bit result into the internal partial-result register;
- update the carry register;
- increment counter k.
REQ-018 On the edge processing chunk k = NCH-1, SHALL:
- load sum from the complete partial result, in one atomic update;
- load cout from the final carry;
- load ovf = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1);
- enter DONE.
REQ-019 Latency: with start accepted at edge E0, result and done SHALL be visible after edge E_NCH, i.e. NCH clocks later.
REQ-020 busy SHALL equal 1 exactly while in RUN. done SHALL equal 1 exactly while in DONE, which lasts one cycle. DONE SHALL return to IDLE unless start=1 (REQ-016).
REQ-021 start while in RUN SHALL be ignored: no restart, and operands and mode unchanged.
REQ-022 sum, cout and ovf SHALL hold their last completed values through IDLE and through the following RUN, until the next completion. They SHALL never show partial results.
REQ-023 Changes to a, b, mode and cin after the accepting edge SHALL NOT affect the operation in progress.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH. The result SHALL be identical to a single-cycle WIDTH-bit add of the latched operands and initial carry, for every legal CHUNK.
REQ-025 When CHUNK = WIDTH (NCH = 1), SHALL complete in one RUN cycle, with done after edge E1.

Reset
REQ-026 When rst=1 on an edge, SHALL force: state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, counter=0, carry=0.
REQ-027 rst SHALL have priority over start.
REQ-028 rst asserted mid-RUN SHALL abort the operation, with no done pulse and no result update.
REQ-029 The first start SHALL be accepted on the first edge with rst=0.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-030 A bench SHALL cover add without carry: add 0x1234 + 0x4321, cin=0 -> sum=0x5555, cout=0, ovf=0; busy high for 4 cycles; done one pulse 4 clocks after start.
REQ-031 A bench SHALL cover add with carry and overflow:
- 0xFFFF + 0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0;
- 0x7FFF + 0x0001 -> sum=0x8000, cout=0, ovf=1;
- 0x0000 + 0x0000, cin=1 -> sum=0x0001.
REQ-032 A bench SHALL cover subtract:
- 0x0005 - 0x0009 -> sum=0xFFFC, cout=0, ovf=0;
- 0x8000 - 0x0001 -> sum=0x7FFF, cout=1, ovf=1.
REQ-033 A bench SHALL cover protocol: start re-pulsed with different a and b during RUN is ignored, and the original result is produced. start held high in DONE starts back-to-back, with done pulses NCH+1 clocks apart.
REQ-034 A bench SHALL cover reset: rst=1 on the 2nd RUN cycle -> next cycle busy=0, done=0, sum=0, cout=0, ovf=0. No done follows.
REQ-035 A bench SHALL cover WIDTH=4, CHUNK=4:
- 5 + 9 -> sum=1110, cout=0;
- 11 + 4 -> 1111, cout=0;
- 15 + 9 -> 1000, cout=1;
- 2 + 3 -> 0101;
- done 1 clock after each start.

Source files
------------

// File: rtl/multicycle_addsub.sv
// Chunk-serial adder/subtractor: processes CHUNK bits per clock and publishes
// sum/cout/ovf atomically when the last chunk has been added.
module multicycle_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_part;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic [CHUNK-1:0] w_ca;
  logic [CHUNK-1:0] w_cb;
  logic [CHUNK-1:0] w_cs;
  logic             w_cout;
  logic [WIDTH-1:0] w_part_nxt;
  logic             w_last;
  logic             w_accept;
  logic             w_ovf;

  function automatic logic [CHUNK:0] add_chunk(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             ci);
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
  endfunction

  always_comb begin
    w_ca       = r_opa[int'(r_cnt)*CHUNK +: CHUNK];
    w_cb       = r_opb[int'(r_cnt)*CHUNK +: CHUNK];
    {w_cout, w_cs} = add_chunk(w_ca, w_cb, r_carry);
    w_part_nxt = r_part;
    w_part_nxt[int'(r_cnt)*CHUNK +: CHUNK] = w_cs;
    w_last     = (r_cnt == CW'(NCH - 1));
    w_accept   = start && (r_state != RUN);
    // carry into the MSB is recovered as a^b^s at that bit, so no extra tap is needed
    w_ovf      = r_opa[WIDTH-1] ^ r_opb[WIDTH-1] ^ w_part_nxt[WIDTH-1] ^ w_cout;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: if (start) w_state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = start ? RUN : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_carry <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (w_accept) begin
      r_opa   <= a;
      r_opb   <= mode ? ~b : b;
      r_carry <= mode ? 1'b1 : cin;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_part  <= w_part_nxt;
      r_carry <= w_cout;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        sum  <= w_part_nxt;
        cout <= w_cout;
        ovf  <= w_ovf;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_addsub.sv
// Directed + randomized bench for multicycle_addsub at 16/4 and 4/4 geometries,
// checked against an integer-arithmetic reference of add/subtract semantics.
module tb_multicycle_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, mode, cin;
  logic [15:0] a, b;
  logic        busy, done, cout, ovf;
  logic [15:0] sum;

  logic        start4, mode4, cin4;
  logic [3:0]  a4, b4;
  logic        busy4, done4, cout4, ovf4;
  logic [3:0]  sum4;

  multicycle_addsub #(.WIDTH(16), .CHUNK(4)) u_dut16 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  multicycle_addsub #(.WIDTH(4), .CHUNK(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .mode(mode4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] e_sum;
  logic        e_cout, e_ovf;
  logic [3:0]  e_sum4;
  logic        e_cout4, e_ovf4;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic void model(input int w, input longint ua, input longint ub,
                                input bit md, input bit ci,
                                output longint s, output bit co, output bit ov);
    longint m, t, sa, sb, sr;
    m  = longint'(1) << w;
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (!md) begin
      t  = ua + ub + longint'(ci);
      co = (t >= m);
      sr = sa + sb + longint'(ci);
    end else begin
      t  = ua - ub;
      co = (ua >= ub);
      sr = sa - sb;
    end
    s  = ((t % m) + m) % m;
    ov = (sr >= m / 2) || (sr < -(m / 2));
  endfunction

  task automatic op16(input logic [15:0] ta, input logic [15:0] tb_, input bit md,
                      input bit ci, input bit garble);
    longint s;
    bit     co, ov;
    model(16, longint'(ta), longint'(tb_), md, ci, s, co, ov);
    a = ta; b = tb_; mode = md; cin = ci; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("busy_run", busy, 1);
      chk("done_run", done, 0);
      chk("sum_hold", sum, e_sum);
      if (garble) begin
        a = 16'($urandom); b = 16'($urandom);
        mode = 1'($urandom); cin = 1'($urandom);
        start = (i == 1) ? 1'b1 : 1'($urandom);
      end
      tick;
    end
    e_sum = 16'(s); e_cout = co; e_ovf = ov;
    chk("busy_done", busy, 0);
    chk("done_pulse", done, 1);
    chk("sum", sum, e_sum);
    chk("cout", cout, e_cout);
    chk("ovf", ovf, e_ovf);
    start = 1'b0;
    tick;
    chk("done_one_cycle", done, 0);
    chk("busy_idle", busy, 0);
    chk("sum_idle_hold", sum, e_sum);
  endtask

  task automatic op4(input logic [3:0] ta, input logic [3:0] tb_, input bit md, input bit ci);
    longint s;
    bit     co, ov;
    model(4, longint'(ta), longint'(tb_), md, ci, s, co, ov);
    a4 = ta; b4 = tb_; mode4 = md; cin4 = ci; start4 = 1'b1;
    tick;
    start4 = 1'b0;
    chk("w4_busy", busy4, 1);
    chk("w4_done_early", done4, 0);
    tick;
    e_sum4 = 4'(s); e_cout4 = co; e_ovf4 = ov;
    chk("w4_done", done4, 1);
    chk("w4_sum", sum4, e_sum4);
    chk("w4_cout", cout4, e_cout4);
    chk("w4_ovf", ovf4, e_ovf4);
    tick;
    chk("w4_done_clear", done4, 0);
  endtask

  task automatic back_to_back;
    longint s1, s2;
    bit     c1, c2, o1, o2;
    int     cyc;
    model(16, 64'h0123, 64'h0F0F, 1'b0, 1'b1, s1, c1, o1);
    model(16, 64'h9000, 64'h1234, 1'b1, 1'b0, s2, c2, o2);
    a = 16'h0123; b = 16'h0F0F; mode = 1'b0; cin = 1'b1; start = 1'b1;
    tick;
    a = 16'h9000; b = 16'h1234; mode = 1'b1; cin = 1'b0;
    cyc = 0;
    while (!done && cyc < 20) begin tick; cyc++; end
    chk("b2b_first_latency", cyc, 4);
    chk("b2b_first_sum", sum, 16'(s1));
    cyc = 0;
    do begin
      tick; cyc++;
      if (cyc == 1) start = 1'b0;
    end while (!done && cyc < 20);
    chk("b2b_spacing", cyc, 5);
    chk("b2b_second_sum", sum, 16'(s2));
    chk("b2b_second_cout", cout, c2);
    chk("b2b_second_ovf", ovf, o2);
    e_sum = 16'(s2); e_cout = c2; e_ovf = o2;
    tick;
  endtask

  task automatic reset_midrun;
    bit seen_done;
    a = 16'hAAAA; b = 16'h5555; mode = 1'b0; cin = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (done) seen_done = 1'b1;
    end
    chk("rst_no_done", seen_done, 0);
    e_sum = '0; e_cout = 1'b0; e_ovf = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; cin = 1'b0; a = '0; b = '0;
    start4 = 1'b0; mode4 = 1'b0; cin4 = 1'b0; a4 = '0; b4 = '0;
    e_sum = '0; e_cout = 1'b0; e_ovf = 1'b0;
    tick; tick;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_sum", sum, 0);
    chk("reset_cout", cout, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_w4_sum", sum4, 0);
    rst = 1'b0;

    op16(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
    op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    op16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    op16(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    op16(16'h0005, 16'h0009, 1'b1, 1'b1, 1'b0);
    op16(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0);
    op16(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);

    back_to_back;
    reset_midrun;

    rst = 1'b1;
    tick;
    rst = 1'b0;
    op16(16'hBEEF, 16'h1234, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++)
      op16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);

    op4(4'd5, 4'd9, 1'b0, 1'b0);
    op4(4'd11, 4'd4, 1'b0, 1'b0);
    op4(4'd15, 4'd9, 1'b0, 1'b0);
    op4(4'd2, 4'd3, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      op4(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
